sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Three-port arbiter sharing the single SDRAM controller port between the video refresh fetcher, the CPU memory bus and a DMA/loader engine. It sits between the requesters inside the system top and the SDRAM controller's native request interface. It serialises one transaction at a time with fixed priority plus anti-starvation for the DMA port, and returns per-port completion pulses and read data.

## Interface
- `ADDR_W`, default 24: word address width presented to the SDRAM controller.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `STARVE_MAX`, default 64: number of CPU grants taken while DMA is pending before DMA is promoted above CPU.

- `clk` in 1: system clock, the same clock as the SDRAM controller's user side.
- `reset_i` in 1: synchronous, active-high reset.
- `req_i` in 3: per-port request; bit 0 = video, 1 = CPU, 2 = DMA.
- `we_i` in 3: per-port write flag; bit 0 is ignored because video is read-only.
- `addr_i` in 3*ADDR_W: per-port address; port n occupies slice n.
- `wdata_i` in 3*DATA_W: per-port write data.
- `be_i` in 3*DATA_W/8: per-port byte enables.
- `gnt_o` out 3: one-cycle grant pulse; the request has been latched.
- `done_o` out 3: one-cycle completion pulse; for reads, `rdata_o` is valid in the same cycle.
- `rdata_o` out DATA_W: read data, shared by all ports.
- `mem_req_o` out 1: request to the SDRAM controller; held until `mem_ack_i`.
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o` out: latched transaction fields.
- `mem_ack_i` in 1: controller accepted the request (writes are complete on ack).
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in DATA_W: read data from the controller.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD. Only one transaction is outstanding at a time.
- In IDLE with any `req_i` set: select the winner, latch its we/addr/wdata/be into `mem_*`, and go to ISSUE.
- Priority order:
  - video highest;
  - then DMA if the starvation counter equals STARVE_MAX;
  - then CPU;
  - then DMA.
- Starvation counter:
  - increments (saturating at STARVE_MAX) on each CPU grant issued while `req_i[2]` is set;
  - clears on a DMA grant.
- In ISSUE: `mem_req_o`=1. `gnt_o[winner]`=1 in the first ISSUE cycle only.
- ISSUE exit on `mem_ack_i`:
  - write: go to IDLE and pulse `done_o[winner]`.
  - read with `mem_rvalid_i` in the same cycle: go to IDLE, capture `rdata_o`, pulse `done_o`.
  - read otherwise: go to WAIT_RD.
- In WAIT_RD, on `mem_rvalid_i`: capture `mem_rdata_i` into `rdata_o`, pulse `done_o[winner]`, go to IDLE.
- `mem_rvalid_i` or `mem_ack_i` arriving while in IDLE is ignored.
- Requesters must hold `req_i` and their fields stable until `gnt_o`. They may deassert or change them from the cycle after `gnt_o`.
- A requester withdrawing `req_i` before grant is legal; no grant is issued to it.
- `rdata_o` holds its last captured value between reads.

## Timing
- Reset values:
  - FSM = IDLE;
  - `gnt_o`, `done_o`, `mem_req_o`, `mem_we_o` = 0;
  - `mem_addr_o`, `mem_wdata_o`, `mem_be_o`, `rdata_o` = 0;
  - starvation counter = 0.
- Reset mid-transaction abandons it with no `done_o`. The controller shares `reset_i`.
- Request in IDLE cycle t → `mem_req_o` and `gnt_o` at t+1.
- Ack at t+1 → `done_o` at t+2. Minimum write period is 2 cycles per transaction.
- Read completion: `done_o` one cycle after `mem_rvalid_i`.
- Back-to-back: the IDLE cycle carrying `done_o` also arbitrates, so the next `mem_req_o` follows 1 cycle after `done_o`.
- All outputs are registered; there is no combinational path from `req_i` to `mem_*`.

## Structure
- Package `sdram_arb_pkg`:
  - port indices `PORT_VIDEO`=0, `PORT_CPU`=1, `PORT_DMA`=2;
  - state enum;
  - `NPORTS`=3.
- Sub-module `sdram_arb_prio`: combinational selector. Inputs are `req`[2:0] and the `starve` flag; outputs are a one-hot winner and its index.
- The FSM, latches and starvation counter live in `sdram_arbiter`.

## Test plan
- Single CPU write, addr 0x000100, data 0xDEADBEEF, ack on first ISSUE cycle → `gnt_o`=3'b010 at t+1, `done_o`=3'b010 at t+2, `mem_we_o`=1.
- Video and CPU read requested in the same cycle → video served first (`gnt_o`=3'b001); CPU granted 1 cycle after video `done_o`; `rdata_o` matches each `mem_rdata_i`.
- CPU continuously requesting with DMA pending → exactly 64 CPU grants, then DMA granted; counter returns to 0.
- Read with `mem_ack_i` and `mem_rvalid_i` in the same cycle (data 0x12345678) → no WAIT_RD, `done_o` next cycle, `rdata_o`=0x12345678.
- `reset_i` asserted in WAIT_RD → next cycle all outputs 0 and no `done_o`. A stray `mem_rvalid_i` afterwards is ignored.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the three-port SDRAM arbiter: port indices and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    localparam logic [1:0] PORT_VIDEO = 2'd0;
    localparam logic [1:0] PORT_CPU   = 2'd1;
    localparam logic [1:0] PORT_DMA   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed-priority winner select: video, then starved DMA, then CPU, then DMA.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module sdram_arb_prio
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              starve,
    output logic [NPORTS-1:0] winner,
    output logic [1:0]        winner_idx
);

    // Pick the single highest-priority requester; DMA jumps CPU only when starved
    always_comb begin
        winner     = '0;
        winner_idx = PORT_VIDEO;
        if (req[PORT_VIDEO]) begin
            winner[PORT_VIDEO] = 1'b1;
            winner_idx         = PORT_VIDEO;
        end else if (req[PORT_DMA] && starve) begin
            winner[PORT_DMA] = 1'b1;
            winner_idx       = PORT_DMA;
        end else if (req[PORT_CPU]) begin
            winner[PORT_CPU] = 1'b1;
            winner_idx       = PORT_CPU;
        end else if (req[PORT_DMA]) begin
            winner[PORT_DMA] = 1'b1;
            winner_idx       = PORT_DMA;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises video/CPU/DMA requests onto one SDRAM controller port, one transaction at a time.
// Latency: request in idle -> mem_req/gnt next cycle; done one cycle after ack (write) or rvalid (read).
// Backpressure: requesters hold req and fields until gnt; mem_req is held until mem_ack.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 64
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NPORTS-1:0]          req_i,
    input  logic [NPORTS-1:0]          we_i,
    input  logic [NPORTS*ADDR_W-1:0]   addr_i,
    input  logic [NPORTS*DATA_W-1:0]   wdata_i,
    input  logic [NPORTS*DATA_W/8-1:0] be_i,
    output logic [NPORTS-1:0]          gnt_o,
    output logic [NPORTS-1:0]          done_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [DATA_W/8-1:0]        mem_be_o,
    input  logic                       mem_ack_i,
    input  logic                       mem_rvalid_i,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t              state;
    logic [NPORTS-1:0]   owner;
    logic [CNT_W-1:0]    starve_cnt;
    logic                starve;
    logic                arbitrate;

    logic [NPORTS-1:0]   win;
    logic [1:0]          win_idx;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

    assign starve    = (starve_cnt == CNT_W'(STARVE_MAX));
    assign arbitrate = (state == ST_IDLE) && (|req_i);

    sdram_arb_prio u_prio (
        .req        (req_i),
        .starve     (starve),
        .winner     (win),
        .winner_idx (win_idx)
    );

    // Route the winning port's transaction fields; video never writes
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (win[p]) begin
                sel_we    = we_i[p] && (p != int'(PORT_VIDEO));
                sel_addr  = addr_i[p*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[p*DATA_W +: DATA_W];
                sel_be    = be_i[p*BE_W +: BE_W];
            end
        end
    end

    // Count CPU grants that overtook a waiting DMA request; a DMA grant clears it
    always_ff @(posedge clk) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (arbitrate) begin
            if (win_idx == PORT_DMA) begin
                starve_cnt <= '0;
            end else if (win_idx == PORT_CPU && req_i[PORT_DMA] && !starve) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Transaction FSM: latch winner, hold request until ack, then wait for read data
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            owner       <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            case (state)
                ST_IDLE: begin
                    // Stray ack/rvalid here belong to nothing and are dropped
                    if (|req_i) begin
                        owner       <= win;
                        gnt_o       <= win;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= sel_we;
                        mem_addr_o  <= sel_addr;
                        mem_wdata_o <= sel_wdata;
                        mem_be_o    <= sel_be;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            done_o <= owner;
                            state  <= ST_IDLE;
                        end else if (mem_rvalid_i) begin
                            rdata_o <= mem_rdata_i;
                            done_o  <= owner;
                            state   <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rvalid_i) begin
                        rdata_o <= mem_rdata_i;
                        done_o  <= owner;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table, directed corner sequences, random vs reference model.
// Latency: n/a.
// Backpressure: bench plays both the requesters and the SDRAM controller.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SMAX = 64;

    logic            clk = 1'b0;
    logic            reset_i = 1'b0;
    logic [2:0]      req_i = '0;
    logic [2:0]      we_i = '0;
    logic [3*AW-1:0] addr_i;
    logic [3*DW-1:0] wdata_i;
    logic [11:0]     be_i;
    logic [2:0]      gnt_o, done_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [3:0]      mem_be_o;
    logic            mem_ack_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [DW-1:0]   mem_rdata_i = '0;

    logic [AW-1:0]   p_addr [3];
    logic [DW-1:0]   p_wdata[3];
    logic [3:0]      p_be   [3];

    assign addr_i  = {p_addr[2], p_addr[1], p_addr[0]};
    assign wdata_i = {p_wdata[2], p_wdata[1], p_wdata[0]};
    assign be_i    = {p_be[2], p_be[1], p_be[0]};

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   gnt_o, 0);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_mreq"},  mem_req_o, 0);
        chk({tag, "_mwe"},   mem_we_o, 0);
        chk({tag, "_maddr"}, mem_addr_o, 0);
        chk({tag, "_mwdat"}, mem_wdata_o, 0);
        chk({tag, "_mbe"},   mem_be_o, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
    endtask

    // Priority rule from the port definition: video, starved DMA, CPU, DMA
    function automatic int ref_pick(input logic [2:0] r, input bit starved);
        if (r[0]) return 0;
        if (r[2] && starved) return 2;
        if (r[1]) return 1;
        return 2;
    endfunction

    // Drive CPU+DMA requests continuously, acking every issue at once; count CPU grants until DMA wins
    task automatic starve_run(output int ncpu, output bit seen);
        ncpu = 0;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step;
            if (gnt_o == 3'b010) ncpu++;
            mem_ack_i = mem_req_o;
            if (gnt_o == 3'b100) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [31:0] rdat;
        logic [2:0]  exp_gnt;
        logic        exp_we;
    } vec_t;

    vec_t tbl[8];

    // random-phase model state
    bit          pend[3];
    int          m_owner, m_cnt, w, granted;
    bit          m_acked, m_wr;
    logic [31:0] m_rd;
    logic [2:0]  a_req, a_we, e_gnt, e_done;
    logic        a_ack, a_rv;
    logic [31:0] a_rdat;
    logic [AW-1:0] a_addr[3];
    logic [DW-1:0] a_wdata[3];
    logic [3:0]    a_be[3];

    initial begin
        int          ncpu, pidx;
        bit          seen;
        logic [31:0] last_rd;

        p_addr[0] = 24'h000010; p_wdata[0] = 32'h0;         p_be[0] = 4'hF;
        p_addr[1] = 24'h000100; p_wdata[1] = 32'hDEADBEEF;  p_be[1] = 4'h3;
        p_addr[2] = 24'h000300; p_wdata[2] = 32'hA5A50003;  p_be[2] = 4'hC;

        tbl[0] = '{3'b010, 3'b010, 32'h0,        3'b010, 1'b1};
        tbl[1] = '{3'b001, 3'b001, 32'h11110000, 3'b001, 1'b0};
        tbl[2] = '{3'b100, 3'b000, 32'h22223333, 3'b100, 1'b0};
        tbl[3] = '{3'b111, 3'b110, 32'h44445555, 3'b001, 1'b0};
        tbl[4] = '{3'b110, 3'b110, 32'h0,        3'b010, 1'b1};
        tbl[5] = '{3'b110, 3'b000, 32'h12345678, 3'b010, 1'b0};
        tbl[6] = '{3'b101, 3'b100, 32'h66667777, 3'b001, 1'b0};
        tbl[7] = '{3'b100, 3'b100, 32'h0,        3'b100, 1'b1};

        // reset state
        reset_i = 1'b1;
        step; step;
        chk_all_zero("rst");
        reset_i = 1'b0;
        step;

        // table: one transaction per vector, acked in the first issue cycle
        last_rd = '0;
        for (int i = 0; i < 8; i++) begin
            req_i = tbl[i].req; we_i = tbl[i].we;
            mem_ack_i = 1'b0; mem_rvalid_i = 1'b0;
            pidx = tbl[i].exp_gnt[2] ? 2 : (tbl[i].exp_gnt[1] ? 1 : 0);
            step;
            chk($sformatf("v%0d_gnt", i), gnt_o, tbl[i].exp_gnt);
            chk($sformatf("v%0d_mreq", i), mem_req_o, 1);
            chk($sformatf("v%0d_mwe", i), mem_we_o, tbl[i].exp_we);
            chk($sformatf("v%0d_maddr", i), mem_addr_o, p_addr[pidx]);
            chk($sformatf("v%0d_mbe", i), mem_be_o, p_be[pidx]);
            if (tbl[i].exp_we) chk($sformatf("v%0d_mwdat", i), mem_wdata_o, p_wdata[pidx]);
            req_i = 3'b000; we_i = 3'b000;
            mem_ack_i = 1'b1; mem_rvalid_i = !tbl[i].exp_we; mem_rdata_i = tbl[i].rdat;
            step;
            if (!tbl[i].exp_we) last_rd = tbl[i].rdat;
            chk($sformatf("v%0d_done", i), done_o, tbl[i].exp_gnt);
            chk($sformatf("v%0d_gnt_off", i), gnt_o, 0);
            chk($sformatf("v%0d_mreq_off", i), mem_req_o, 0);
            chk($sformatf("v%0d_rdata", i), rdata_o, last_rd);
            mem_ack_i = 1'b0; mem_rvalid_i = 1'b0;
        end

        // video + CPU read together: video first via WAIT_RD, CPU one cycle after video done
        req_i = 3'b011; we_i = 3'b000;
        step;
        chk("vc_gnt_video", gnt_o, 3'b001);
        req_i = 3'b010; mem_ack_i = 1'b1;
        step;
        chk("vc_waitrd_done", done_o, 0);
        chk("vc_waitrd_mreq", mem_req_o, 0);
        mem_ack_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
        step;
        chk("vc_done_video", done_o, 3'b001);
        chk("vc_rdata_video", rdata_o, 32'hCAFE0001);
        chk("vc_no_early_gnt", gnt_o, 0);
        mem_rvalid_i = 1'b0;
        step;
        chk("vc_gnt_cpu", gnt_o, 3'b010);
        chk("vc_mreq_cpu", mem_req_o, 1);
        req_i = 3'b000; mem_ack_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0002;
        step;
        chk("vc_done_cpu", done_o, 3'b010);
        chk("vc_rdata_cpu", rdata_o, 32'hCAFE0002);
        mem_ack_i = 1'b0; mem_rvalid_i = 1'b0;
        step;

        // starvation: 64 CPU grants then DMA; counter cleared so another 64 follow
        reset_i = 1'b1; step; reset_i = 1'b0;
        req_i = 3'b110; we_i = 3'b110;
        starve_run(ncpu, seen);
        chk("starve1_dma_seen", seen, 1);
        chk("starve1_cpu_grants", ncpu, SMAX);
        starve_run(ncpu, seen);
        chk("starve2_dma_seen", seen, 1);
        chk("starve2_cpu_grants", ncpu, SMAX);
        req_i = 3'b000; we_i = 3'b000;
        for (int c = 0; c < 4; c++) begin
            step;
            mem_ack_i = mem_req_o;
        end
        mem_ack_i = 1'b0;

        // reset while waiting for read data: abandoned, stray rvalid ignored
        req_i = 3'b010; we_i = 3'b000;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        step;
        chk("rwait_gnt", gnt_o, 3'b010);
        req_i = 3'b000; mem_rvalid_i = 1'b0; mem_ack_i = 1'b1;
        step;
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'h0BADF00D;
        step;
        chk("rwait_held_done", done_o, 0);
        mem_rdata_i = 32'hABCD1234;
        step;
        chk("rwait_rdata_hold", rdata_o, 32'h0);
        reset_i = 1'b1;
        step;
        chk_all_zero("rwait_rst");
        reset_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        step;
        chk("stray_rv_done", done_o, 0);
        chk("stray_rv_rdata", rdata_o, 0);
        mem_rvalid_i = 1'b0;
        step;
        chk("stray_rv_gnt", gnt_o, 0);
        chk("stray_rv_mreq", mem_req_o, 0);

        // random traffic against the transaction-level model
        reset_i = 1'b1; req_i = '0; we_i = '0; mem_ack_i = 1'b0; mem_rvalid_i = 1'b0;
        step;
        reset_i = 1'b0;
        m_owner = -1; m_acked = 1'b0; m_wr = 1'b0; m_cnt = 0; m_rd = '0;
        for (int p = 0; p < 3; p++) pend[p] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_req = req_i; a_we = we_i; a_ack = mem_ack_i; a_rv = mem_rvalid_i; a_rdat = mem_rdata_i;
            for (int p = 0; p < 3; p++) begin
                a_addr[p] = p_addr[p]; a_wdata[p] = p_wdata[p]; a_be[p] = p_be[p];
            end
            step;
            e_gnt = '0; e_done = '0; granted = -1;
            if (m_owner < 0) begin
                if (a_req != 3'b000) begin
                    w = ref_pick(a_req, m_cnt == SMAX);
                    e_gnt = 3'(1 << w);
                    granted = w;
                    if (w == 2) m_cnt = 0;
                    else if (w == 1 && a_req[2] && m_cnt < SMAX) m_cnt++;
                    m_owner = w; m_acked = 1'b0;
                    m_wr = (w != 0) && a_we[w];
                end
            end else if (!m_acked) begin
                if (a_ack) begin
                    if (m_wr || a_rv) begin
                        e_done = 3'(1 << m_owner);
                        if (!m_wr) m_rd = a_rdat;
                        m_owner = -1;
                    end else begin
                        m_acked = 1'b1;
                    end
                end
            end else if (a_rv) begin
                e_done = 3'(1 << m_owner);
                m_rd = a_rdat;
                m_owner = -1;
            end
            chk("rnd_gnt", gnt_o, e_gnt);
            chk("rnd_done", done_o, e_done);
            chk("rnd_mreq", mem_req_o, (m_owner >= 0) && !m_acked);
            chk("rnd_rdata", rdata_o, m_rd);
            if (granted >= 0) begin
                chk("rnd_mwe", mem_we_o, m_wr);
                chk("rnd_maddr", mem_addr_o, a_addr[granted]);
                chk("rnd_mbe", mem_be_o, a_be[granted]);
                if (m_wr) chk("rnd_mwdat", mem_wdata_o, a_wdata[granted]);
                pend[granted] = 1'b0;
            end
            // controller side
            if (m_owner >= 0 && !m_acked) begin
                mem_ack_i = ($urandom_range(1) == 1);
                mem_rvalid_i = mem_ack_i && ($urandom_range(1) == 1);
            end else if (m_owner >= 0) begin
                mem_ack_i = 1'b0;
                mem_rvalid_i = ($urandom_range(1) == 1);
            end else begin
                mem_ack_i = ($urandom_range(7) == 0);
                mem_rvalid_i = ($urandom_range(7) == 0);
            end
            mem_rdata_i = $urandom;
            // requesters: hold fields while pending, occasionally withdraw
            for (int p = 0; p < 3; p++) begin
                if (pend[p]) begin
                    if ($urandom_range(31) == 0) pend[p] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    pend[p] = 1'b1;
                    we_i[p] = ($urandom_range(1) == 1);
                    p_addr[p] = AW'($urandom);
                    p_wdata[p] = $urandom;
                    p_be[p] = 4'($urandom);
                end
                req_i[p] = pend[p];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
